// File: rtl/parity_engine.sv
// Parity generator (TX) and frame parity checker (RX) with latched per-frame config.
// Define PARITY_ERR_CNT_EN to add the saturating error counter (err_clr / err_cnt).
module parity_engine #(
    parameter int MAX_WIDTH = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 PAR_EN,
    input  logic [1:0]           PAR_MODE,
    input  logic [3:0]           DATA_LEN,
    input  logic [MAX_WIDTH-1:0] P_DATA,
    input  logic                 Data_valid,
    input  logic                 FSM_en,
    output logic                 par_bit,
    input  logic                 rx_start,
    input  logic                 rx_bit_valid,
    input  logic                 rx_bit,
    input  logic                 rx_par_strobe,
    input  logic                 rx_par_bit,
`ifdef PARITY_ERR_CNT_EN
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     err_cnt,
`endif
    output logic                 par_chk_done,
    output logic                 par_err
);

    localparam logic [3:0] MAX_L    = 4'(MAX_WIDTH);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_PWAIT  = 2'd2;

    function automatic logic sel_par(input logic [1:0] mode, input logic acc);
        logic r;
        r = 1'b0;
        unique case (mode)
            2'b00: r = acc;
            2'b01: r = ~acc;
            2'b10: r = 1'b1;
            2'b11: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0] eff_len;
    logic       tx_sum;
    logic       par_bit_d, par_bit_q;

    logic [1:0] state_d, state_q;
    logic       acc_d, acc_q;
    logic [3:0] cnt_d, cnt_q;
    logic [3:0] len_d, len_q;
    logic [1:0] mode_d, mode_q;
    logic       en_d, en_q;
    logic       err_d, err_q;
    logic       done_d, done_q;

    assign eff_len = (DATA_LEN == 4'd0 || DATA_LEN > MAX_L) ? MAX_L : DATA_LEN;

    always_comb begin
        tx_sum = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < int'(eff_len)) tx_sum = tx_sum ^ P_DATA[i];
        end
        par_bit_d = par_bit_q;
        if (Data_valid && FSM_en) begin
            par_bit_d = PAR_EN ? sel_par(PAR_MODE, tx_sum) : 1'b0;
        end
    end

    // rx_start overrides everything, including a same-cycle data strobe
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        en_d    = en_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (rx_start) begin
            acc_d   = 1'b0;
            cnt_d   = 4'd0;
            err_d   = 1'b0;
            len_d   = eff_len;
            mode_d  = PAR_MODE;
            en_d    = PAR_EN;
            state_d = S_ACCUM;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ACCUM: begin
                    if (rx_bit_valid) begin
                        acc_d = acc_q ^ rx_bit;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == len_q) begin
                            if (en_q) begin
                                state_d = S_PWAIT;
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                                err_d   = 1'b0;
                            end
                        end
                    end
                end
                S_PWAIT: begin
                    if (rx_par_strobe) begin
                        err_d   = rx_par_bit != sel_par(mode_q, acc_q);
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit_q <= 1'b0;
            state_q   <= S_IDLE;
            acc_q     <= 1'b0;
            cnt_q     <= 4'd0;
            len_q     <= 4'd0;
            mode_q    <= 2'b00;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            en_q      <= en_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign par_bit      = par_bit_q;
    assign par_chk_done = done_q;
    assign par_err      = err_q;

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;

    // Counts in the same edge the done pulse is registered
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (done_d && err_d && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) err_cnt_q <= '0;
        else      err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
